multicycle_control_unit: RTL and testbench

Multi-cycle MIPS control unit. A state machine steps each instruction through the IF/ID/EXE/MEM/WB phases and drives every datapath select and write-enable. This includes the 2-bit ExtSel consumed by the immediate sign/zero extender. It sits between the instruction register opcode field and the datapath, one instance per CPU.

---
 rtl/multicycle_control_unit.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: steps each instruction through IF/ID/EXE/MEM/WB
// and drives every datapath select and write-enable from the current state and
// the instruction register opcode.
// Optional build macro CU_ILLEGAL_TRAP_EN: an unknown opcode halts the FSM and
// raises the sticky `illegal` output instead of executing as a NOP.
module multicycle_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] RegDst,
    output logic [1:0] ExtSel,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] state
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b011100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t     state_reg;
    logic       halted_reg;
    logic       illegal_reg;

    logic       is_br, is_ls, is_jmp, is_halt, known, reg_wb;
    logic       src_a, src_b;
    logic [1:0] reg_dst, ext_sel;
    logic [2:0] alu_op;
    logic       br_taken;

    // Opcode decode into instruction class and per-instruction datapath selects
    always_comb begin
        is_br = 1'b0; is_ls = 1'b0; is_jmp = 1'b0; is_halt = 1'b0;
        known = 1'b1; reg_wb = 1'b0; src_a = 1'b0; src_b = 1'b0;
        reg_dst = 2'b00; ext_sel = 2'b10; alu_op = 3'b000;
        case (op)
            OP_ADD:   begin reg_dst = 2'b10; reg_wb = 1'b1; end
            OP_SUB:   begin alu_op = 3'b001; reg_dst = 2'b10; reg_wb = 1'b1; end
            OP_ADDIU: begin src_b = 1'b1; reg_dst = 2'b01; reg_wb = 1'b1; end
            OP_AND:   begin alu_op = 3'b110; reg_dst = 2'b10; reg_wb = 1'b1; end
            OP_ANDI:  begin alu_op = 3'b110; ext_sel = 2'b01; src_b = 1'b1; reg_dst = 2'b01; reg_wb = 1'b1; end
            OP_ORI:   begin alu_op = 3'b101; ext_sel = 2'b01; src_b = 1'b1; reg_dst = 2'b01; reg_wb = 1'b1; end
            OP_XORI:  begin alu_op = 3'b111; ext_sel = 2'b01; src_b = 1'b1; reg_dst = 2'b01; reg_wb = 1'b1; end
            OP_SLL:   begin alu_op = 3'b100; ext_sel = 2'b00; src_a = 1'b1; reg_dst = 2'b10; reg_wb = 1'b1; end
            OP_SLTI:  begin alu_op = 3'b010; src_b = 1'b1; reg_dst = 2'b01; reg_wb = 1'b1; end
            OP_SLT:   begin alu_op = 3'b010; reg_dst = 2'b10; reg_wb = 1'b1; end
            OP_SW:    begin src_b = 1'b1; is_ls = 1'b1; end
            OP_LW:    begin src_b = 1'b1; reg_dst = 2'b01; is_ls = 1'b1; end
            OP_BEQ, OP_BNE: begin alu_op = 3'b001; is_br = 1'b1; end
            OP_BLTZ:  is_br = 1'b1;
            OP_J, OP_JR, OP_JAL: is_jmp = 1'b1;
            default: begin
                if (op == HALT_OP) is_halt = 1'b1;
                else               known   = 1'b0;
            end
        endcase
    end

    assign br_taken = ((op == OP_BEQ) && zero) ||
                      ((op == OP_BNE) && !zero) ||
                      ((op == OP_BLTZ) && sign);

    // State register with halt/illegal flags; reset abandons any instruction in flight
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_reg   <= S_IF;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IF:     if (!halted_reg) state_reg <= S_ID;
                S_ID: begin
                    if (is_jmp) begin
                        state_reg <= S_IF;
                    end else if (is_halt) begin
                        state_reg  <= S_IF;
                        halted_reg <= 1'b1;
                    end else if (is_br) begin
                        state_reg <= S_EXE_BR;
                    end else if (is_ls) begin
                        state_reg <= S_EXE_LS;
`ifdef CU_ILLEGAL_TRAP_EN
                    end else if (!known) begin
                        state_reg   <= S_IF;
                        halted_reg  <= 1'b1;
                        illegal_reg <= 1'b1;
`endif
                    end else begin
                        state_reg <= S_EXE_AL;
                    end
                end
                S_EXE_AL: state_reg <= S_WB_AL;
                S_EXE_BR: state_reg <= S_IF;
                S_EXE_LS: state_reg <= S_MEM;
                S_MEM:    state_reg <= (op == OP_LW) ? S_WB_LD : S_IF;
                default:  state_reg <= S_IF;
            endcase
        end
    end

    // Output decode is combinational so branch resolution can use this cycle's zero/sign
    // and the enables drop immediately when Reset goes low
    always_comb begin
        PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
        DBDataSrc = 1'b0; RegWre = 1'b0; WrRegDSrc = 1'b0; mRD = 1'b0; mWR = 1'b0;
        RegDst = 2'b00; ExtSel = 2'b00; PCSrc = 2'b00; ALUOp = 3'b000;
        if (Reset) begin
            if (state_reg != S_IF) begin
                ALUSrcA = src_a; ALUSrcB = src_b; RegDst = reg_dst;
                ExtSel  = ext_sel; ALUOp = alu_op;
            end
            case (state_reg)
                S_IF: if (!halted_reg) begin IRWre = 1'b1; InsMemRW = 1'b1; end
                S_ID: if (is_jmp) begin
                    PCWre = 1'b1;
                    PCSrc = (op == OP_JR) ? 2'b10 : 2'b11;
                    if (op == OP_JAL) RegWre = 1'b1;
                end
                S_EXE_BR: begin PCWre = 1'b1; if (br_taken) PCSrc = 2'b01; end
                S_MEM:    if (op == OP_LW) mRD = 1'b1; else begin mWR = 1'b1; PCWre = 1'b1; end
                S_WB_AL:  begin PCWre = 1'b1; RegWre = reg_wb; WrRegDSrc = 1'b1; end
                S_WB_LD:  begin PCWre = 1'b1; RegWre = 1'b1; DBDataSrc = 1'b1; WrRegDSrc = 1'b1; end
                default: ;
            endcase
        end
    end

    assign state = state_reg;
`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal = illegal_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver pushes a hand-written
// expected output vector for every cycle, the monitor pops and compares on the
// falling edge.
// Vector layout: {illegal, state[2:0], PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB,
//                 DBDataSrc, RegWre, WrRegDSrc, mRD, mWR, RegDst, ExtSel, PCSrc, ALUOp}
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero, sign;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc;
    logic       RegWre, WrRegDSrc, mRD, mWR;
    logic [1:0] RegDst, ExtSel, PCSrc;
    logic [2:0] ALUOp, state;
    logic       ill_bit;

    int checks = 0;
    int errors = 0;

    logic [22:0] exp_q[$];
    string       tag_q[$];

    localparam logic [21:0] V_IF   = 22'b000_0110000000_00_00_00_000;
    localparam logic [21:0] V_ZERO = 22'b000_0000000000_00_00_00_000;

    always #5 CLK = ~CLK;

    multicycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .RegWre(RegWre),
        .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR), .RegDst(RegDst),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
`ifdef CU_ILLEGAL_TRAP_EN
        , .illegal(ill_bit)
`endif
    );
`ifndef CU_ILLEGAL_TRAP_EN
    assign ill_bit = 1'b0;
`endif

    // Push the expectation for the current cycle, then advance one clock
    task automatic step(input string tag, input logic [21:0] v, input logic ill = 1'b0);
        exp_q.push_back({ill, v});
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare every cycle that has an expectation queued
    always @(negedge CLK) begin
        logic [22:0] act, e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            act = {ill_bit, state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc,
                   RegWre, WrRegDSrc, mRD, mWR, RegDst, ExtSel, PCSrc, ALUOp};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s actual=%b required=%b", t, act, e);
            end else begin
                $display("ok   %s %b", t, act);
            end
        end
    end

    initial begin
        Reset = 1'b0; op = 6'b000000; zero = 1'b0; sign = 1'b0;
        @(posedge CLK); #1;
        step("reset", V_ZERO);
        Reset = 1'b1;

        op = 6'b000000; // add
        step("add IF", V_IF);
        step("add ID", 22'b001_0000000000_10_10_00_000);
        step("add EXE", 22'b110_0000000000_10_10_00_000);
        step("add WB", 22'b111_1000001100_10_10_00_000);

        op = 6'b010010; // ori
        step("ori IF", V_IF);
        step("ori ID", 22'b001_0000100000_01_01_00_101);
        step("ori EXE", 22'b110_0000100000_01_01_00_101);
        step("ori WB", 22'b111_1000101100_01_01_00_101);

        op = 6'b000010; // addiu
        step("addiu IF", V_IF);
        step("addiu ID", 22'b001_0000100000_01_10_00_000);
        step("addiu EXE", 22'b110_0000100000_01_10_00_000);
        step("addiu WB", 22'b111_1000101100_01_10_00_000);

        op = 6'b011000; // sll
        step("sll IF", V_IF);
        step("sll ID", 22'b001_0001000000_10_00_00_100);
        step("sll EXE", 22'b110_0001000000_10_00_00_100);
        step("sll WB", 22'b111_1001001100_10_00_00_100);

        op = 6'b110001; // lw
        step("lw IF", V_IF);
        step("lw ID", 22'b001_0000100000_01_10_00_000);
        step("lw EXE", 22'b010_0000100000_01_10_00_000);
        step("lw MEM", 22'b011_0000100010_01_10_00_000);
        step("lw WB", 22'b100_1000111100_01_10_00_000);

        op = 6'b110000; // sw
        step("sw IF", V_IF);
        step("sw ID", 22'b001_0000100000_00_10_00_000);
        step("sw EXE", 22'b010_0000100000_00_10_00_000);
        step("sw MEM", 22'b011_1000100001_00_10_00_000);

        op = 6'b110100; zero = 1'b1; // beq taken
        step("beq1 IF", V_IF);
        step("beq1 ID", 22'b001_0000000000_00_10_00_001);
        step("beq1 EXE", 22'b101_1000000000_00_10_01_001);

        zero = 1'b0; // beq not taken
        step("beq0 IF", V_IF);
        step("beq0 ID", 22'b001_0000000000_00_10_00_001);
        step("beq0 EXE", 22'b101_1000000000_00_10_00_001);

        op = 6'b110101; // bne, zero=0 -> taken
        step("bne IF", V_IF);
        step("bne ID", 22'b001_0000000000_00_10_00_001);
        step("bne EXE", 22'b101_1000000000_00_10_01_001);

        op = 6'b110110; sign = 1'b1; // bltz taken
        step("bltz IF", V_IF);
        step("bltz ID", 22'b001_0000000000_00_10_00_000);
        step("bltz EXE", 22'b101_1000000000_00_10_01_000);
        sign = 1'b0;

        op = 6'b111010; // jal
        step("jal IF", V_IF);
        step("jal ID", 22'b001_1000001000_00_10_11_000);
        op = 6'b111000; // j
        step("j IF", V_IF);
        step("j ID", 22'b001_1000000000_00_10_11_000);
        op = 6'b111001; // jr
        step("jr IF", V_IF);
        step("jr ID", 22'b001_1000000000_00_10_10_000);

        // Reset while sw is in MEM: write enable drops at once, IF next
        op = 6'b110000;
        step("swr IF", V_IF);
        step("swr ID", 22'b001_0000100000_00_10_00_000);
        step("swr EXE", 22'b010_0000100000_00_10_00_000);
        Reset = 1'b0;
        step("swr MEM rst", 22'b011_0000000000_00_00_00_000);
        Reset = 1'b1;
        step("swr after", V_IF);
        step("swr after ID", 22'b001_0000100000_00_10_00_000);
        step("swr after EXE", 22'b010_0000100000_00_10_00_000);
        step("swr after MEM", 22'b011_1000100001_00_10_00_000);

        // halt parks the FSM; reset resumes in IF
        op = 6'b111111;
        step("halt IF", V_IF);
        step("halt ID", 22'b001_0000000000_00_10_00_000);
        for (int i = 0; i < 10; i++) step("halted", V_ZERO);
        Reset = 1'b0;
        step("halt rst", V_ZERO);
        Reset = 1'b1;
        op = 6'b000000;
        step("resume IF", V_IF);
        step("resume ID", 22'b001_0000000000_10_10_00_000);
        step("resume EXE", 22'b110_0000000000_10_10_00_000);
        step("resume WB", 22'b111_1000001100_10_10_00_000);

        // Unknown opcode
        op = 6'b101010;
        step("unk IF", V_IF);
        step("unk ID", 22'b001_0000000000_00_10_00_000);
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) step("unk trap", V_ZERO, 1'b1);
        Reset = 1'b0;
        step("unk rst", V_ZERO, 1'b1);
        Reset = 1'b1;
        step("unk resume", V_IF);
`else
        step("unk EXE", 22'b110_0000000000_00_10_00_000);
        step("unk WB", 22'b111_1000000100_00_10_00_000);
        step("unk next IF", V_IF);
`endif

        @(negedge CLK);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
